fifo_sc_param: RTL and testbench
================================

FIFO_SC_PARAM -- requirements
Module: fifo_sc_param

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 20, giving the data word width in bits.
REQ-002 The block SHALL have a parameter ADDR_W, default 8, giving depth DEPTH = 2^ADDR_W words (default 256).
REQ-003 The block SHALL have a parameter SHOWAHEAD, default 0: 0 = normal read (registered q), 1 = show-ahead (head word presented on q).
REQ-004 The block SHALL have a parameter AFULL_TH, default 240, as the almost_full threshold; legal range 1..DEPTH.
REQ-005 The block SHALL have a parameter AEMPTY_TH, default 16, as the almost_empty threshold; legal range 0..DEPTH-1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port aclr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port sclr, input, 1 bit: synchronous clear, active-high.
REQ-009 The block SHALL have port data, input, DATA_W bits: the write word.
REQ-010 The block SHALL have port wrreq, input, 1 bit: write request.
REQ-011 The block SHALL have port rdreq, input, 1 bit: read request.
REQ-012 The block SHALL have port q, output, DATA_W bits: the read word.
REQ-013 The block SHALL have port usedw, output, ADDR_W+1 bits: stored word count, 0..DEPTH inclusive.
REQ-014 The block SHALL have ports empty, full, almost_full and almost_empty, each an output of 1 bit: registered level flags.
REQ-015 The block SHALL have ports overflow and underflow, each an output of 1 bit: sticky error flags.

Function
REQ-016 A write SHALL be accepted iff wrreq=1 and full=0; an accepted write stores data at wr_ptr, and wr_ptr then increments modulo DEPTH.
REQ-017 A read SHALL be accepted iff rdreq=1 and empty=0; rd_ptr then increments modulo DEPTH.
REQ-018 On each edge, usedw SHALL become usedw + (write accepted) - (read accepted); simultaneous accepted read and write SHALL leave usedw unchanged.
REQ-019 Acceptance SHALL be evaluated on pre-edge flags: when full with both wrreq and rdreq, the read is accepted and the write rejected; when empty with both, the write is accepted and the read rejected.
REQ-020 All flags SHALL be registered and reflect the post-edge usedw: empty = (usedw==0), full = (usedw==DEPTH), almost_full = (usedw>=AFULL_TH), almost_empty = (usedw<=AEMPTY_TH).
REQ-021 overflow SHALL set on any rejected write (wrreq=1 with full=1) and underflow on any rejected read (rdreq=1 with empty=1); both SHALL hold until sclr or reset.
REQ-022 With SHOWAHEAD=0, q SHALL update one cycle after an accepted read to the word read and SHALL hold its value otherwise, including on rejected reads.
REQ-023 With SHOWAHEAD=1, q SHALL equal the word at rd_ptr whenever empty=0; the first word written into an empty FIFO SHALL appear on q in the same cycle empty deasserts; q is undefined-but-stable while empty=1.
REQ-024 sclr=1 SHALL take priority over wrreq and rdreq: pointers, usedw, flags, overflow/underflow and q return to reset values at the edge, and no write or read occurs in that cycle.
REQ-025 Data order SHALL be preserved across pointer wrap-around with no word lost or duplicated.
REQ-026 Illegal AFULL_TH or AEMPTY_TH values SHALL cause an elaboration-time error.

Reset
REQ-027 While aclr_n=0, outputs SHALL asynchronously take: q=0, usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-028 Storage contents SHALL NOT be reset; reset asserted mid-operation SHALL discard all stored words.
REQ-029 Operation SHALL resume on the first rising clk edge after aclr_n deasserts.

Verification
REQ-030 The bench SHALL check: defaults, write 0x00001, 0x00002, 0x00003, then 3 reads -> q = 1, 2, 3, each one cycle after its read; usedw goes 3 -> 0; empty=1 after the last read.
REQ-031 The bench SHALL check: 256 writes -> almost_full rises as usedw reaches 240 and full=1 at 256; a 257th write -> overflow=1, usedw stays 256; draining returns words 1..256 in order.
REQ-032 The bench SHALL check: at usedw=10, wrreq=rdreq=1 -> usedw stays 10; at full, both requests -> usedw=255, overflow=1.
REQ-033 The bench SHALL check: when empty, rdreq alone -> underflow=1 and q held; when empty, both requests -> usedw=1, underflow=1.
REQ-034 The bench SHALL check: stream 300 words with random wrreq/rdreq -> output order matches input order across pointer wrap; sclr at usedw=100 with wrreq=1 -> usedw=0, empty=1, overflow=0; aclr_n pulsed low mid-stream -> all REQ-027 values take effect immediately, without waiting for a clock edge.
REQ-035 The bench SHALL check: SHOWAHEAD=1, write 0xABCDE into an empty FIFO -> next cycle empty=0 and q=0xABCDE with rdreq=0; rdreq=1 -> empty=1 and usedw=0 on the following cycle.

Source files
------------

// File: rtl/fifo_sc_param.sv
// Single-clock parameterised FIFO with registered level flags, sticky error flags
// and a selectable normal (registered q) or show-ahead read port.
module fifo_sc_param #(
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 8,
  parameter int SHOWAHEAD = 0,
  parameter int AFULL_TH  = 240,
  parameter int AEMPTY_TH = 16
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              sclr,
  input  logic [DATA_W-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W:0]   usedw,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W:0] cnt_t;

  localparam cnt_t DEPTH_LVL  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_LVL  = cnt_t'(AFULL_TH);
  localparam cnt_t AEMPTY_LVL = cnt_t'(AEMPTY_TH);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull_th
    $error("fifo_sc_param: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty_th
    $error("fifo_sc_param: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  cnt_t              usedw_next;

  // Acceptance uses the registered (pre-edge) flags; sclr suppresses both sides.
  assign wr_acc     = wrreq & ~full & ~sclr;
  assign rd_acc     = rdreq & ~empty & ~sclr;
  assign usedw_next = usedw + cnt_t'(wr_acc) - cnt_t'(rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (sclr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      usedw        <= usedw_next;
      empty        <= (usedw_next == '0);
      full         <= (usedw_next == DEPTH_LVL);
      almost_full  <= (usedw_next >= AFULL_LVL);
      almost_empty <= (usedw_next <= AEMPTY_LVL);
      if (wrreq && full) begin
        overflow <= 1'b1;
      end
      if (rdreq && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Show-ahead presents the head word combinationally; zero is shown while empty.
  if (SHOWAHEAD != 0) begin : g_showahead
    assign q = empty ? '0 : mem[rd_ptr];
  end else begin : g_normal
    always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
        q <= '0;
      end else if (sclr) begin
        q <= '0;
      end else if (rd_acc) begin
        q <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_sc_param.sv
// Randomised and directed bench for fifo_sc_param, checked against a queue-based
// model of the FIFO; a second instance exercises the show-ahead read port.
module tb_fifo_sc_param;

  localparam int DW    = 20;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AF    = 240;
  localparam int AE    = 16;

  logic          clk    = 1'b0;
  logic          aclr_n = 1'b1;
  logic          sclr   = 1'b0;
  logic          wrreq  = 1'b0;
  logic          rdreq  = 1'b0;
  logic [DW-1:0] data   = '0;

  logic [DW-1:0] q, sa_q;
  logic [AW:0]   usedw, sa_usedw;
  logic empty, full, almost_full, almost_empty, overflow, underflow;
  logic sa_empty, sa_full, sa_almost_full, sa_almost_empty, sa_overflow, sa_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q;
  bit            m_ovf;
  bit            m_unf;

  fifo_sc_param #(.DATA_W(DW), .ADDR_W(AW), .SHOWAHEAD(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .usedw(usedw), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  fifo_sc_param #(.DATA_W(DW), .ADDR_W(AW), .SHOWAHEAD(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut_sa (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(sa_q), .usedw(sa_usedw), .empty(sa_empty), .full(sa_full), .almost_full(sa_almost_full),
    .almost_empty(sa_almost_empty), .overflow(sa_overflow), .underflow(sa_underflow)
  );

  always #5 clk = ~clk;

  // Expected {empty, full, almost_full, almost_empty} for a given occupancy.
  function automatic logic [3:0] flags_for(int n);
    return {n == 0, n == DEPTH, n >= AF, n <= AE};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_q   = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Advance the model with the current inputs, then step past the next rising edge.
  task automatic tick();
    bit was_full;
    bit was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (!aclr_n || sclr) begin
      model_reset();
    end else begin
      if (rdreq && !was_empty) m_q = mq.pop_front();
      else if (rdreq) m_unf = 1'b1;
      if (wrreq && !was_full) mq.push_back(data);
      else if (wrreq) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_sclr();
    sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0;
    tick();
    sclr = 1'b0;
  endtask

  task automatic test_reset();
    #1 aclr_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({q, usedw} !== {{DW{1'b0}}, {(AW+1){1'b0}}}) begin
      n_fail++; $display("[TB] FAIL reset_q_usedw: got q=%0h usedw=%0d expected 0/0", q, usedw);
    end
    n_checks++;
    if ({empty, full, almost_full, almost_empty, overflow, underflow} !== 6'b100100) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 100100",
               {empty, full, almost_full, almost_empty, overflow, underflow});
    end
    n_checks++;
    if (sa_q !== '0 || sa_empty !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_sa: got q=%0h empty=%b expected 0/1", sa_q, sa_empty);
    end
    @(posedge clk);
    #3 aclr_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) begin
      data = DW'(i); wrreq = 1'b1;
      tick();
    end
    wrreq = 1'b0;
    n_checks++;
    if (usedw !== 9'd3) begin
      n_fail++; $display("[TB] FAIL basic_usedw3: got %0d expected 3", usedw);
    end
    for (int i = 1; i <= 3; i++) begin
      rdreq = 1'b1;
      tick();
      n_checks++;
      if (q !== DW'(i) || usedw !== 9'(3 - i)) begin
        n_fail++;
        $display("[TB] FAIL basic_read%0d: got q=%0h usedw=%0d expected %0h/%0d", i, q, usedw, i, 3 - i);
      end
    end
    rdreq = 1'b0;
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++; $display("[TB] FAIL basic_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= DEPTH; k++) begin
      data = DW'(k); wrreq = 1'b1;
      tick();
      n_checks++;
      if (usedw !== 9'(k) || almost_full !== (k >= AF) || full !== (k == DEPTH)) begin
        n_fail++;
        $display("[TB] FAIL fill_%0d: got usedw=%0d af=%b full=%b expected %0d/%b/%b",
                 k, usedw, almost_full, full, k, k >= AF, k == DEPTH);
      end
    end
    data = 20'hFFFFF;
    tick();
    wrreq = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || usedw !== 9'd256) begin
      n_fail++; $display("[TB] FAIL fill_overflow: got ovf=%b usedw=%0d expected 1/256", overflow, usedw);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      rdreq = 1'b1;
      tick();
      n_checks++;
      if (q !== DW'(k) || almost_empty !== (mq.size() <= AE)) begin
        n_fail++;
        $display("[TB] FAIL drain_%0d: got q=%0h ae=%b expected %0h/%b", k, q, almost_empty, k, mq.size() <= AE);
      end
    end
    rdreq = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("[TB] FAIL drain_end: got empty=%b ovf=%b expected 1/1", empty, overflow);
    end
    do_sclr();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sclr_ovf: got %b expected 0", overflow);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 10; i++) begin
      data = DW'($urandom); wrreq = 1'b1;
      tick();
    end
    data = DW'($urandom); rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    n_checks++;
    if (usedw !== 9'd10 || q !== m_q) begin
      n_fail++; $display("[TB] FAIL simul_mid: got usedw=%0d q=%0h expected 10/%0h", usedw, q, m_q);
    end
    for (int i = 0; i < 300 && mq.size() < DEPTH; i++) begin
      data = DW'($urandom);
      tick();
    end
    rdreq = 1'b1;
    tick();
    wrreq = 1'b0; rdreq = 1'b0;
    n_checks++;
    if (usedw !== 9'd255 || overflow !== 1'b1 || q !== m_q) begin
      n_fail++;
      $display("[TB] FAIL simul_full: got usedw=%0d ovf=%b q=%0h expected 255/1/%0h", usedw, overflow, q, m_q);
    end
    do_sclr();
  endtask

  task automatic test_underflow();
    logic [DW-1:0] w;
    w = DW'($urandom) | 20'h1;
    data = w; wrreq = 1'b1;
    tick();
    wrreq = 1'b0; rdreq = 1'b1;
    tick();
    tick();
    rdreq = 1'b0;
    n_checks++;
    if (underflow !== 1'b1 || q !== w) begin
      n_fail++; $display("[TB] FAIL unf_read: got unf=%b q=%0h expected 1/%0h", underflow, q, w);
    end
    data = DW'($urandom); wrreq = 1'b1; rdreq = 1'b1;
    tick();
    wrreq = 1'b0; rdreq = 1'b0;
    n_checks++;
    if (usedw !== 9'd1 || underflow !== 1'b1 || q !== w) begin
      n_fail++;
      $display("[TB] FAIL unf_both: got usedw=%0d unf=%b q=%0h expected 1/1/%0h", usedw, underflow, q, w);
    end
    do_sclr();
  endtask

  task automatic test_stream();
    int written;
    written = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (written == 300 && mq.size() == 0) break;
      wrreq = (written < 300) && ($urandom_range(0, 3) < ((cyc < 400) ? 3 : 2));
      rdreq = ($urandom_range(0, 3) < ((cyc < 250) ? 1 : 3));
      data  = DW'($urandom);
      if (wrreq && mq.size() < DEPTH) written++;
      tick();
      n_checks++;
      if (usedw !== 9'(mq.size()) || q !== m_q ||
          {empty, full, almost_full, almost_empty} !== flags_for(mq.size()) ||
          {overflow, underflow} !== {m_ovf, m_unf}) begin
        n_fail++;
        $display("[TB] FAIL stream_c%0d: got usedw=%0d q=%0h flags=%b err=%b expected %0d/%0h/%b/%b",
                 cyc, usedw, q, {empty, full, almost_full, almost_empty}, {overflow, underflow},
                 mq.size(), m_q, flags_for(mq.size()), {m_ovf, m_unf});
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (sa_q !== mq[0]) begin
          n_fail++; $display("[TB] FAIL stream_sa_c%0d: got %0h expected %0h", cyc, sa_q, mq[0]);
        end
      end
    end
    wrreq = 1'b0; rdreq = 1'b0;
    n_checks++;
    if (written != 300 || mq.size() != 0) begin
      n_fail++; $display("[TB] FAIL stream_timeout: got written=%0d left=%0d expected 300/0", written, mq.size());
    end
  endtask

  task automatic test_sclr();
    do_sclr();
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    for (int i = 0; i < 100; i++) begin
      data = DW'($urandom); wrreq = 1'b1;
      tick();
    end
    n_checks++;
    if (usedw !== 9'd100 || underflow !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sclr_pre: got usedw=%0d unf=%b expected 100/1", usedw, underflow);
    end
    sclr = 1'b1;
    tick();
    sclr = 1'b0; wrreq = 1'b0;
    n_checks++;
    if (usedw !== '0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || q !== '0) begin
      n_fail++;
      $display("[TB] FAIL sclr_post: got usedw=%0d empty=%b ovf=%b unf=%b q=%0h expected 0/1/0/0/0",
               usedw, empty, overflow, underflow, q);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) begin
      data = DW'($urandom) | 20'h1; wrreq = 1'b1;
      tick();
    end
    wrreq = 1'b0; rdreq = 1'b1; data = 20'h0;
    for (int i = 0; i < 5; i++) tick();
    rdreq = 1'b0;
    wrreq = 1'b1; rdreq = 1'b1;
    #1 aclr_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (q !== '0 || usedw !== '0 || sa_q !== '0 ||
        {empty, full, almost_full, almost_empty, overflow, underflow} !== 6'b100100) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got q=%0h usedw=%0d sa_q=%0h flags=%b expected 0/0/0/100100",
               q, usedw, sa_q, {empty, full, almost_full, almost_empty, overflow, underflow});
    end
    wrreq = 1'b0; rdreq = 1'b0;
    @(posedge clk);
    #2 aclr_n = 1'b1;
    data = 20'h12345; wrreq = 1'b1;
    tick();
    wrreq = 1'b0;
    n_checks++;
    if (usedw !== 9'd1) begin
      n_fail++; $display("[TB] FAIL async_discard: got usedw=%0d expected 1", usedw);
    end
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    n_checks++;
    if (q !== 20'h12345 || empty !== 1'b1) begin
      n_fail++; $display("[TB] FAIL async_resume: got q=%0h empty=%b expected 12345/1", q, empty);
    end
  endtask

  task automatic test_showahead();
    do_sclr();
    data = 20'hABCDE; wrreq = 1'b1;
    tick();
    wrreq = 1'b0;
    n_checks++;
    if (sa_empty !== 1'b0 || sa_q !== 20'hABCDE) begin
      n_fail++; $display("[TB] FAIL sa_first: got empty=%b q=%0h expected 0/abcde", sa_empty, sa_q);
    end
    tick();
    n_checks++;
    if (sa_q !== 20'hABCDE || sa_usedw !== 9'd1) begin
      n_fail++; $display("[TB] FAIL sa_hold: got q=%0h usedw=%0d expected abcde/1", sa_q, sa_usedw);
    end
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    n_checks++;
    if (sa_empty !== 1'b1 || sa_usedw !== '0) begin
      n_fail++; $display("[TB] FAIL sa_read: got empty=%b usedw=%0d expected 1/0", sa_empty, sa_usedw);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_simultaneous();
    test_underflow();
    test_stream();
    test_sclr();
    test_async_reset();
    test_showahead();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
